// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the sequential ALU.
// ALU_DIV_EN selects whether DIVU/REMU are iterative ops or undefined opcodes.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REMU = 4'b1010;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ITER_MUL  = 2'd0,
    ITER_DIVU = 2'd1,
    ITER_REMU = 2'd2
  } iter_op_e;

  function automatic logic is_iterative(input logic [3:0] ctrl);
`ifdef ALU_DIV_EN
    return (ctrl == ALU_MUL) || (ctrl == ALU_DIVU) || (ctrl == ALU_REMU);
`else
    return (ctrl == ALU_MUL);
`endif
  endfunction

  function automatic iter_op_e iter_op_of(input logic [3:0] ctrl);
    case (ctrl)
      ALU_DIVU: return ITER_DIVU;
      ALU_REMU: return ITER_REMU;
      default:  return ITER_MUL;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle for alu_seq: valid/ready request with
// operands and opcode, valid/ready response with registered result and zero flag.
interface alu_seq_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, src_a, src_b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_ctrl, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply and (with ALU_DIV_EN) restoring
// unsigned divide, one bit per cycle; done strobes with the final result.
module alu_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  iter_op_e         op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  iter_op_e         op_q, op_d;
  // acc: product (MUL) or partial remainder (DIV); opa: multiplicand or divisor;
  // opb: multiplier shifting out, or dividend shifting out while quotient shifts in.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
`ifdef ALU_DIV_EN
    rem_shift = '0;
    diff      = '0;
`endif
    if (start) begin
      cnt_d = CNT_W'(WIDTH);
      op_d  = op;
      acc_d = '0;
      opa_d = op_a;
      opb_d = op_b;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (op_q == ITER_MUL) begin
        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
`ifdef ALU_DIV_EN
      else begin
        // A zero divisor never underflows, giving all-ones quotient and remainder = dividend.
        rem_shift = {acc_q, opb_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, opa_q};
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], 1'b0};
        end
      end
`endif
    end
  end

  assign done   = (cnt_q == CNT_W'(1));
  assign result = (op_q == ITER_DIVU) ? opb_d : acc_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, so a discarded op leaves no stale partial state.
      cnt_q <= '0;
      op_q  <= ITER_MUL;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic plus iterative MUL and, when
// ALU_DIV_EN is defined, DIVU/REMU; one operation in flight, registered result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             is_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] alu_y;
  logic             load_single;
  logic             load_iter;

  assign accept      = bus.in_valid & bus.in_ready;
  assign is_iter     = is_iterative(bus.alu_ctrl);
  assign iter_start  = accept & is_iter;
  assign load_single = accept & ~is_iter;
  assign load_iter   = (state_q == ST_BUSY) & iter_done;

  always_comb begin
    alu_y = '0;
    case (bus.alu_ctrl)
      ALU_AND:  alu_y = bus.src_a & bus.src_b;
      ALU_OR:   alu_y = bus.src_a | bus.src_b;
      ALU_ADD:  alu_y = bus.src_a + bus.src_b;
      ALU_XOR:  alu_y = bus.src_a ^ bus.src_b;
      ALU_SUB:  alu_y = bus.src_a - bus.src_b;
      ALU_SLT:  alu_y = WIDTH'($signed(bus.src_a) < $signed(bus.src_b));
      ALU_NOR:  alu_y = ~(bus.src_a | bus.src_b);
      ALU_SLTU: alu_y = WIDTH'(bus.src_a < bus.src_b);
      default:  alu_y = '0;
    endcase
  end

  alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .op     (iter_op_of(bus.alu_ctrl)),
    .op_a   (bus.src_a),
    .op_b   (bus.src_b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)                              state_d = is_iter ? ST_BUSY : ST_DONE;
        else if (state_q == ST_DONE && !bus.out_ready) state_d = ST_DONE;
        else                                     state_d = ST_IDLE;
      end
      ST_BUSY: if (iter_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready looks through to out_ready so a draining result frees the slot in the same cycle.
  always_comb begin
    bus.in_ready  = !reset && (state_q == ST_IDLE || (state_q == ST_DONE && bus.out_ready));
    bus.out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    if (load_single) begin
      result_d = alu_y;
      zero_d   = (alu_y == '0);
    end else if (load_iter) begin
      result_d = iter_result;
      zero_d   = (iter_result == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomized ops against a
// plain-arithmetic reference model; a monitor pops and compares every result.
module tb_alu_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   or_mode = 1;    // 0: hold out_ready low, 1: always ready, 2: random
  bit   in_reset = 1'b1;
  bit   front_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: return ~(a | b);
      4'b1111: return (a < b) ? W'(1) : W'(0);
      4'b1000: return a * b;
`ifdef ALU_DIV_EN
      4'b1001: return (b == 0) ? {W{1'b1}} : a / b;
      4'b1010: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] c);
`ifdef ALU_DIV_EN
    if (c == 4'b1001 || c == 4'b1010) return W + 1;
`endif
    return (c == 4'b1000) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return W'($urandom_range(0, 15));
      3:       return W'(1) << $urandom_range(0, W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  // out_ready driver: changes only on the falling edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                       input logic [W-1:0] exp, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.src_a    = a;
    bus.src_b    = b;
    bus.alu_ctrl = c;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
    end else begin
      e.res     = exp;
      e.lat     = lat_of(c);
      e.acc_cyc = cyc;
      @(posedge clk);
      q.push_back(e);
      #1;
      bus.in_valid = 1'b0;
      bus.src_a    = W'($urandom);
      bus.src_b    = W'($urandom);
      bus.alu_ctrl = 4'($urandom);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", q.size(), 0);
  endtask

  // monitor: compares every presented result, pops on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("spurious_valid", bus.out_valid, 0);
          end else begin
            e = q[0];
            if (!front_seen) begin
              check("latency", cyc - e.acc_cyc, e.lat);
              front_seen = 1'b1;
            end
            check("result", bus.result, e.res);
            check("zero", bus.zero, (e.res == '0));
            check("in_ready_done", bus.in_ready, bus.out_ready);
            if (bus.out_ready) begin
              void'(q.pop_front());
              front_seen = 1'b0;
            end
          end
        end else if (q.size() != 0) begin
          check("in_ready_busy", bus.in_ready, 0);
        end
      end
    end
  end

  initial begin
    int w;
    logic [3:0] codes[13];
    logic [W-1:0] a, b;
    logic [3:0] c;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1100,
              4'b1111, 4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1101};

    bus.in_valid = 1'b0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.alu_ctrl = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    in_reset = 1'b0;

    // directed single-cycle ops, back-to-back
    issue(10, 20, 4'b0010, 30, w);
    issue(30, 30, 4'b0110, 0, w);
    check("b2b_accept_wait", w, 0);
    issue(-5, 10, 4'b0111, 1, w);
    issue(-5, 10, 4'b1111, 0, w);
    issue(32'hF0F0, 32'h0FF0, 4'b0000, 32'h00F0, w);
    issue(32'h1234, 32'h5678, 4'b0011, 0, w);
    issue(32'hFFFF_FFFF, 1, 4'b0010, 0, w);

    // iterative ops
    issue(7, 6, 4'b1000, 42, w);
    issue(32'hFFFF_FFFF, 2, 4'b1000, 32'hFFFF_FFFE, w);
`ifdef ALU_DIV_EN
    issue(100, 7, 4'b1001, 14, w);
    issue(100, 7, 4'b1010, 2, w);
    issue(5, 0, 4'b1001, 32'hFFFF_FFFF, w);
    issue(5, 0, 4'b1010, 5, w);
`else
    issue(100, 7, 4'b1001, 0, w);
    issue(100, 7, 4'b1010, 0, w);
`endif
    drain();

    // backpressure: result held while out_ready is low
    or_mode = 0;
    issue(1, 1, 4'b0010, 2, w);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.result, 2);
      check("bp_in_ready", bus.in_ready, 0);
    end
    or_mode = 1;
    @(negedge clk);
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_valid", bus.out_valid, 1);
    drain();

    // reset in the middle of a multiply
    issue(5, 5, 4'b0110, 0, w);
    issue(7, 6, 4'b1000, 42, w);
    repeat (9) @(negedge clk);
    in_reset   = 1'b1;
    reset      = 1'b1;
    q.delete();
    front_seen = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_zero", bus.zero, 0);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    in_reset = 1'b0;
    issue(3, 4, 4'b0010, 7, w);
    drain();

    // randomized ops with random backpressure and idle gaps
    or_mode = 2;
    for (int i = 0; i < 150; i++) begin
      c = codes[$urandom_range(0, 12)];
      a = rnd_operand();
      b = rnd_operand();
      issue(a, b, c, model(c, a, b), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    or_mode = 1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked ALU; successor to the 3-bit-control combinational 32-bit ALU. Single-cycle logic/arithmetic ops plus iterative multiply and unsigned divide/remainder, one bit per cycle. Valid/ready on input and output; one operation in flight. Sits between decode/issue and writeback in the multi-cycle core.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 8..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operation offered.
in_ready  out  1  operation accepted when in_valid & in_ready.
src_a  in  WIDTH  operand A.
src_b  in  WIDTH  operand B.
alu_ctrl  in  4  operation code.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  registered result.
zero  out  1  registered, (result == 0).

Behaviour:
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0100 XOR; 0110 SUB; 0111 SLT (signed); 1100 NOR; 1111 SLTU; 1000 MUL (low WIDTH bits of product); 1001 DIVU (quotient); 1010 REMU (remainder). Any other code is single-cycle, result 0.
- ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU give 1 or 0, zero-extended.
- States: IDLE, BUSY, DONE.
- IDLE: accept a single-cycle op -> DONE next edge, result/zero loaded. Accept MUL/DIVU/REMU -> BUSY, operands latched, counter = WIDTH.
- BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements. At counter == 1, load result/zero and go to DONE. MUL/DIV latency = WIDTH+1 cycles from accept to out_valid.
- Single-cycle op latency: 1 cycle.
- DONE: out_valid = 1; result and zero held stable until out_valid & out_ready.
- On out_ready in DONE: go to IDLE, or directly to DONE/BUSY if a new op is accepted the same cycle.
- in_ready = !reset & (state == IDLE | (state == DONE & out_ready)). This is a combinational path from out_ready to in_ready. It gives back-to-back single-cycle throughput of 1 op/cycle.
- in_ready = 0 in BUSY. in_valid is ignored when in_ready = 0.
- Divide by zero: quotient = all ones; remainder = src_a. Still takes WIDTH+1 cycles, with no early exit.
- Operands are latched at accept; later changes on src_a/src_b/alu_ctrl have no effect.
- Reset (any state, including mid-BUSY): state = IDLE, out_valid = 0, result = 0, zero = 0, counter = 0, partial product/remainder registers = 0. The in-flight op is discarded. in_ready = 1 from the first cycle after reset deasserts.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: DIVU/REMU behave as above.
- Undefined: no divider logic; codes 1001/1010 are treated as undefined opcodes (single-cycle, result 0, zero = 1). MUL is unaffected.

Decomposition:
- Package alu_pkg: opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLTU, ALU_MUL, ALU_DIVU, ALU_REMU), state encoding localparams, and the is_iterative(ctrl) function.
- Sub-module alu_iter: the iterative mul/div datapath, with start, op, operands, done strobe and result. It owns the counter and shift registers.
- alu_seq holds the combinational single-cycle ALU, the FSM and the output register.

Test Plan:
- ADD 10+20, out_ready = 1 -> out_valid 1 cycle after accept, result = 30, zero = 0. Then SUB 30-30 accepted back-to-back -> result = 0, zero = 1 on the next cycle.
- SLT src_a = -5, src_b = 10 -> result = 1. SLTU same operands -> result = 0. AND 0xF0F0 & 0x0FF0 -> 0x00F0.
- MUL 7*6 -> out_valid exactly WIDTH+1 (33) cycles after accept, result = 42. in_ready = 0 throughout BUSY. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. With ALU_DIV_EN undefined, DIVU 100/7 -> 0 after 1 cycle, zero = 1.
- Backpressure: ADD 1+1 with out_ready = 0 for 5 cycles -> out_valid stays 1, result = 2 stable, in_ready = 0. out_ready = 1 -> handshake completes, in_ready = 1 in the same cycle.
- Reset asserted 10 cycles into a MUL -> next cycle out_valid = 0, result = 0, zero = 0. After deassert, in_ready = 1 and a fresh ADD 3+4 -> 7.
